// File: rtl/ifetch.sv
// ifetch: instruction fetch stage with redirect, hazard stall, HALT detection and
// a multi-cycle instruction-memory handshake.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'hFC00_0000
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic        stall_f_hz,
  input  logic        branch_taken_f_ex,
  input  logic [31:0] branch_target_f_ex,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_2_id,
  output logic [31:0] pc4_out_2_id,
  output logic        inst_valid_2_id,
  output logic        halted,
  output logic [15:0] fetch_cnt
);
  typedef enum logic [1:0] {S_FETCH, S_STALL, S_HALT} state_t;
  state_t      r_state, w_state;
  logic        r_run, r_valid, w_valid;
  logic [31:0] r_pc, w_pc, r_inst, w_inst, r_pc4, w_pc4, w_pc_inc;
  logic [15:0] r_cnt, w_cnt;
  assign w_pc_inc        = r_pc + 32'd4;
  assign imem_req        = r_run && r_state == S_FETCH && !stall_f_hz;
  assign imem_addr       = r_pc;
  assign inst_2_id       = r_inst;
  assign pc4_out_2_id    = r_pc4;
  assign inst_valid_2_id = r_valid;
  assign halted          = r_state == S_HALT;
  assign fetch_cnt       = r_cnt;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_inst  = r_inst;
    w_pc4   = r_pc4;
    w_valid = r_valid;
    w_cnt   = r_cnt;
    if (branch_taken_f_ex) begin
      w_state = S_FETCH;
      w_pc    = {branch_target_f_ex[31:2], 2'b00};
      w_inst  = NOP_INST;
      w_valid = 1'b0;
    end else if (r_state == S_HALT) begin
      w_inst  = NOP_INST;
      w_valid = 1'b0;
    end else if (stall_f_hz) begin
      w_state = S_STALL;
    end else if (r_state == S_STALL) begin
      w_state = S_FETCH;
    end else if (imem_ack) begin
      w_state = imem_rdata[31:26] == 6'b010001 ? S_HALT : S_FETCH;
      w_pc    = w_pc_inc;
      w_inst  = imem_rdata;
      w_pc4   = w_pc_inc;
      w_valid = 1'b1;
      w_cnt   = r_cnt == 16'hFFFF ? r_cnt : r_cnt + 16'd1;
    end else begin
      w_inst  = NOP_INST;
      w_valid = 1'b0;
    end
  end
  // r_run delays operation by one edge so reset release is taken synchronously
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_run   <= 1'b0;
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_pc4   <= 32'd0;
      r_valid <= 1'b0;
      r_cnt   <= 16'd0;
    end else if (!r_run) begin
      r_run   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_inst  <= w_inst;
      r_pc4   <= w_pc4;
      r_valid <= w_valid;
      r_cnt   <= w_cnt;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized and directed checks of ifetch against a cycle-level
// reference model of the fetch rules.
module tb_ifetch;
  localparam logic [31:0] NOP = 32'hFC00_0000;
  logic        clk1 = 1'b0, reset = 1'b0, stall_f_hz = 1'b0, branch_taken_f_ex = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target_f_ex = 32'd0, imem_rdata = 32'd0;
  logic        imem_req, inst_valid_2_id, halted;
  logic [31:0] imem_addr, inst_2_id, pc4_out_2_id;
  logic [15:0] fetch_cnt;
  int n_chk = 0, n_pass = 0;
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  int          m_mode;
  int unsigned m_deliv;

  ifetch dut (
    .clk1(clk1), .reset(reset), .stall_f_hz(stall_f_hz),
    .branch_taken_f_ex(branch_taken_f_ex), .branch_target_f_ex(branch_target_f_ex),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_2_id(inst_2_id), .pc4_out_2_id(pc4_out_2_id), .inst_valid_2_id(inst_valid_2_id),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] m_cnt();
    return m_deliv > 32'd65535 ? 32'h0000_FFFF : m_deliv;
  endfunction

  task automatic do_reset();
    @(negedge clk1);
    stall_f_hz = 0; branch_taken_f_ex = 0; imem_ack = 0;
    reset = 0;
    #1;
    chk("rst_inst", inst_2_id, NOP);
    chk("rst_valid", 32'(inst_valid_2_id), 0);
    chk("rst_pc4", pc4_out_2_id, 0);
    chk("rst_cnt", 32'(fetch_cnt), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", 32'(imem_req), 0);
    @(negedge clk1);
    reset = 1;
    #1 chk("req_pre_edge", 32'(imem_req), 0);
    @(posedge clk1);
    #1 chk("req_first", 32'(imem_req), 1);
    m_pc = 0; m_inst = NOP; m_pc4 = 0; m_valid = 0; m_mode = 0; m_deliv = 0;
  endtask

  // m_mode: 0 fetching, 1 stalled, 2 halted
  task automatic step(input logic s, input logic b, input logic [31:0] t, input logic a, input logic [31:0] d);
    @(negedge clk1);
    stall_f_hz = s; branch_taken_f_ex = b; branch_target_f_ex = t; imem_ack = a; imem_rdata = d;
    #1;
    chk("req", 32'(imem_req), 32'(m_mode == 0 && !s));
    chk("addr", imem_addr, m_pc);
    chk("halted", 32'(halted), 32'(m_mode == 2));
    if (b) begin
      m_pc = t & ~32'd3; m_inst = NOP; m_valid = 0; m_mode = 0;
    end else if (m_mode == 2) begin
      m_inst = NOP; m_valid = 0;
    end else if (s || m_mode == 1) begin
      m_mode = s ? 1 : 0;
    end else if (a) begin
      m_pc = m_pc + 4; m_inst = d; m_pc4 = m_pc; m_valid = 1; m_deliv++;
      if (d[31:26] == 6'b010001) m_mode = 2;
    end else begin
      m_inst = NOP; m_valid = 0;
    end
    @(posedge clk1);
    #1;
    chk("inst", inst_2_id, m_inst);
    chk("pc4", pc4_out_2_id, m_pc4);
    chk("valid", 32'(inst_valid_2_id), 32'(m_valid));
    chk("cnt", 32'(fetch_cnt), m_cnt());
  endtask

  initial begin
    logic [31:0] d;
    logic [5:0]  op;
    do_reset();
    step(0, 0, 0, 1, 32'h0400_0001);
    chk("seq_inst0", inst_2_id, 32'h0400_0001);
    chk("seq_pc4_0", pc4_out_2_id, 32'h4);
    step(0, 0, 0, 1, 32'h0800_0002);
    chk("seq_pc4_1", pc4_out_2_id, 32'h8);
    chk("seq_cnt", 32'(fetch_cnt), 2);
    step(0, 1, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_bubble", inst_2_id, NOP);
    end
    step(0, 0, 0, 1, 32'h0000_1111);
    chk("wait_pc4", pc4_out_2_id, 32'h14);
    step(0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 1, 32'h0000_2222);
    step(1, 0, 0, 1, 32'h0000_3333);
    step(1, 0, 0, 1, 32'h0000_3333);
    chk("stall_hold", inst_2_id, 32'h0000_2222);
    chk("stall_req", 32'(imem_req), 0);
    step(0, 0, 0, 1, 32'h0000_4444);
    step(0, 0, 0, 0, 0);
    chk("stall_resume", imem_addr, 32'h24);
    step(0, 1, 32'h0000_0103, 1, 32'h0000_5555);
    chk("redir_valid", 32'(inst_valid_2_id), 0);
    chk("redir_pc", imem_addr, 32'h100);
    chk("redir_cnt", 32'(fetch_cnt), 4);
    step(0, 0, 0, 1, 32'h4400_0000);
    chk("halt_deliv", 32'(inst_valid_2_id), 1);
    for (int i = 0; i < 4; i++) step(i[0], 0, 0, 1, 32'h0000_6666);
    chk("halt_flag", 32'(halted), 1);
    step(0, 1, 32'h40, 0, 0);
    chk("halt_exit", imem_addr, 32'h40);
    step(0, 0, 0, 1, 32'h0000_7777);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else begin
        op = 6'($urandom_range(0, 63));
        if (op == 6'b010001) op = 6'd0;
        d = $urandom_range(0, 15) == 0 ? {6'b010001, 26'($urandom)} : {op, 26'($urandom)};
        step($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, $urandom,
             1'($urandom_range(0, 1)), d);
      end
    end
    do_reset();
    step(0, 1, 32'hFFFF_FFF0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h0000_0013);
    chk("wrap_pc4", pc4_out_2_id, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    while (m_deliv < 32'd65540) step(0, 0, 0, 1, 32'h0000_0013);
    chk("sat_cnt", 32'(fetch_cnt), 32'h0000_FFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
